mem_arbiter: RTL and testbench

Sequential arbiter that shares the single RAM port between the instruction cache and the data cache. It sits between both caches and main memory, serialises their requests one transaction at a time, and holds each loser's wait high until its own access completes. Data accesses take priority, and a bounded-streak rule guarantees that instruction fetch cannot starve.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the single RAM port.
// The arbiter takes the slave view; the cache/RAM environment takes the master view.
interface mem_arbiter_if;
    // instruction cache side
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    // data cache side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    // RAM side
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises icache and dcache accesses onto one RAM port. Data wins by default;
// after MAX_DSTREAK consecutive data completions with a fetch pending, fetch is forced.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] MAX_STREAK = 4'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] dstreak_q, dstreak_d;

    logic dreq;
    logic i_done;
    logic d_done;

    assign dreq   = bus.dREN | bus.dWEN;
    assign i_done = (state_q == IGRANT) & bus.ramready;
    assign d_done = (state_q == DGRANT) & bus.ramready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            dstreak_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
        end
    end

    // Waits depend only on the raw request and the completion condition, so a
    // withdrawn or idle requester never stalls.
    always_comb begin
        bus.iwait = bus.iREN & ~i_done;
        bus.dwait = dreq & ~d_done;
    end

    always_comb begin
        state_d      = state_q;
        dstreak_d    = dstreak_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'd0;
        bus.ramstore = 32'd0;
        bus.iload    = 32'd0;
        bus.dload    = 32'd0;

        case (state_q)
            IDLE: begin
                if (dreq && !(bus.iREN && (dstreak_q == MAX_STREAK))) begin
                    state_d = DGRANT;
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                end
            end

            IGRANT: begin
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (bus.ramready) begin
                        bus.iload = bus.ramload;
                        state_d   = IDLE;
                        dstreak_d = 4'd0;
                    end
                end
            end

            DGRANT: begin
                if (!dreq) begin
                    state_d = IDLE;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    // a write takes precedence when both strobes are raised
                    if (bus.dWEN) begin
                        bus.ramWEN = 1'b1;
                    end else begin
                        bus.ramREN = 1'b1;
                    end
                    if (bus.ramready) begin
                        bus.dload = bus.ramload;
                        state_d   = IDLE;
                        if (bus.iREN) begin
                            dstreak_d = (dstreak_q == MAX_STREAK) ? MAX_STREAK
                                                                  : dstreak_q + 4'd1;
                        end else begin
                            dstreak_d = 4'd0;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

    localparam int MAXD = 4;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_DSTREAK(MAXD)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // model: who owns the RAM port (0 none, 1 icache, 2 dcache) and the D streak
    int owner = 0;
    int streak = 0;
    int owner_n = 0;
    int streak_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to the falling edge, predict every output from the model and compare.
    task automatic settle();
        logic        dreq;
        logic        e_iw, e_dw, e_rr, e_rw;
        logic [31:0] e_il, e_dl, e_ra, e_rs;
        #4;
        dreq = bus.dREN | bus.dWEN;
        e_iw = bus.iREN;
        e_dw = dreq;
        e_rr = 1'b0;
        e_rw = 1'b0;
        e_il = 32'd0;
        e_dl = 32'd0;
        e_ra = 32'd0;
        e_rs = 32'd0;
        if (!nRST) begin
            owner  = 0;
            streak = 0;
        end
        owner_n  = 0;
        streak_n = streak;
        if (owner == 0) begin
            if (dreq && !(bus.iREN && streak == MAXD)) owner_n = 2;
            else if (bus.iREN) owner_n = 1;
        end else if (owner == 1 && bus.iREN) begin
            e_rr = 1'b1;
            e_ra = bus.iaddr;
            if (bus.ramready) begin
                e_iw     = 1'b0;
                e_il     = bus.ramload;
                streak_n = 0;
            end else begin
                owner_n = 1;
            end
        end else if (owner == 2 && dreq) begin
            e_ra = bus.daddr;
            e_rs = bus.dstore;
            if (bus.dWEN) e_rw = 1'b1;
            else          e_rr = 1'b1;
            if (bus.ramready) begin
                e_dw     = 1'b0;
                e_dl     = bus.ramload;
                streak_n = bus.iREN ? ((streak < MAXD) ? streak + 1 : MAXD) : 0;
            end else begin
                owner_n = 2;
            end
        end
        chk("iwait",    32'(bus.iwait),  32'(e_iw));
        chk("dwait",    32'(bus.dwait),  32'(e_dw));
        chk("ramREN",   32'(bus.ramREN), 32'(e_rr));
        chk("ramWEN",   32'(bus.ramWEN), 32'(e_rw));
        chk("ramaddr",  bus.ramaddr,     e_ra);
        chk("ramstore", bus.ramstore,    e_rs);
        chk("iload",    bus.iload,       e_il);
        chk("dload",    bus.dload,       e_dl);
    endtask

    task automatic advance();
        @(posedge CLK);
        if (nRST) begin
            owner  = owner_n;
            streak = streak_n;
        end else begin
            owner  = 0;
            streak = 0;
        end
        #1;
    endtask

    initial begin
        nRST         = 1'b0;
        bus.iREN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b0;
        bus.iaddr    = 32'h40;
        bus.daddr    = 32'h100;
        bus.dstore   = 32'd0;
        bus.ramready = 1'b0;
        bus.ramload  = 32'd0;
        #1;

        // reset held with both requests up
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("rst_iwait",  32'(bus.iwait),  32'd1);
            chk("rst_dwait",  32'(bus.dwait),  32'd1);
            chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
            advance();
        end
        nRST = 1'b1;
        settle();
        advance();
        settle();
        chk("first_grant_ren",  32'(bus.ramREN), 32'd1);
        chk("first_grant_addr", bus.ramaddr,     32'h100);
        advance();
        bus.ramready = 1'b1;
        bus.ramload  = 32'h1234;
        settle();
        chk("first_d_done", 32'(bus.dwait), 32'd0);
        chk("first_dload",  bus.dload,      32'h1234);
        advance();
        bus.dREN = 1'b0; bus.iREN = 1'b0; bus.ramready = 1'b0;
        settle();
        advance();

        // single I read with three-cycle RAM latency
        bus.iREN = 1'b1;
        settle();
        advance();
        for (int c = 0; c < 3; c++) begin
            bus.ramready = (c == 2);
            bus.ramload  = (c == 2) ? 32'h8C010004 : $urandom;
            settle();
            chk("iread_ren",   32'(bus.ramREN), 32'd1);
            chk("iread_addr",  bus.ramaddr,     32'h40);
            chk("iread_iwait", 32'(bus.iwait),  (c == 2) ? 32'd0 : 32'd1);
            chk("iread_iload", bus.iload,       (c == 2) ? 32'h8C010004 : 32'd0);
            advance();
        end
        bus.ramready = 1'b0;
        settle();
        chk("turnaround_ren",   32'(bus.ramREN), 32'd0);
        chk("turnaround_iwait", 32'(bus.iwait),  32'd1);
        advance();

        // abort: iREN withdrawn while granted, pending D takes over
        bus.iREN  = 1'b0;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h100;
        settle();
        chk("abort_ren",  32'(bus.ramREN), 32'd0);
        chk("abort_addr", bus.ramaddr,     32'd0);
        advance();
        settle();
        advance();
        bus.ramready = 1'b1;
        settle();
        chk("after_abort_ren",  32'(bus.ramREN), 32'd1);
        chk("after_abort_addr", bus.ramaddr,     32'h100);
        advance();
        bus.dREN = 1'b0; bus.ramready = 1'b0;
        settle();
        advance();

        // combined write+read: write wins
        bus.dREN   = 1'b1;
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h200;
        bus.dstore = 32'hDEADBEEF;
        settle();
        advance();
        settle();
        chk("dw_wen",   32'(bus.ramWEN), 32'd1);
        chk("dw_ren",   32'(bus.ramREN), 32'd0);
        chk("dw_store", bus.ramstore,    32'hDEADBEEF);
        advance();
        bus.ramready = 1'b1;
        settle();
        chk("dw_done", 32'(bus.dwait), 32'd0);
        advance();
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramready = 1'b0;
        settle();
        advance();

        // both sides saturating: every fifth grant goes to I
        bus.iREN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.iaddr    = 32'h40;
        bus.daddr    = 32'h100;
        bus.ramready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            settle();
            if (k % 2 == 1) begin
                chk("streak_grant", bus.ramaddr, (((k + 1) / 2) % 5 == 0) ? 32'h40 : 32'h100);
            end else begin
                chk("streak_idle", 32'(bus.ramREN), 32'd0);
            end
            advance();
        end

        // asynchronous reset in the middle of a D write
        bus.iREN     = 1'b0;
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h300;
        bus.dstore   = 32'h55;
        bus.ramready = 1'b0;
        settle();
        advance();
        settle();
        chk("pre_rst_wen", 32'(bus.ramWEN), 32'd1);
        #1 nRST = 1'b0;
        #1;
        chk("async_rst_wen",   32'(bus.ramWEN), 32'd0);
        chk("async_rst_ren",   32'(bus.ramREN), 32'd0);
        chk("async_rst_dwait", 32'(bus.dwait),  32'd1);
        advance();
        settle();
        advance();
        nRST = 1'b1;
        settle();
        advance();
        bus.ramready = 1'b1;
        settle();
        chk("regrant_wen",  32'(bus.ramWEN), 32'd1);
        chk("regrant_addr", bus.ramaddr,     32'h300);
        advance();
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramready = 1'b0;
        settle();
        advance();

        // randomized traffic with sticky requests and random RAM latency
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(7) == 0) begin
                bus.iREN = ~bus.iREN;
                if (bus.iREN) bus.iaddr = $urandom;
            end
            if ($urandom_range(5) == 0) begin
                if (bus.dREN | bus.dWEN) begin
                    bus.dREN = 1'b0;
                    bus.dWEN = 1'b0;
                end else begin
                    {bus.dREN, bus.dWEN} = 2'($urandom_range(1, 3));
                    bus.daddr  = $urandom;
                    bus.dstore = $urandom;
                end
            end
            bus.ramready = ($urandom_range(2) == 0);
            bus.ramload  = $urandom;
            settle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
